// File: rtl/riscv_arb_pkg.sv
// riscv_arb_pkg: shared widths, payload type and round-robin index helper for the data-port arbiter
package riscv_arb_pkg;
  localparam int ARB_NB_REQ = 2;
  localparam int ARB_IDX_W = $clog2(ARB_NB_REQ);
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  atop;
  } arb_req_t;
  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/riscv_data_port_arbiter_if.sv
// riscv_data_port_arbiter_if: requester-side and data-memory-side signals of the data-port arbiter
interface riscv_data_port_arbiter_if #(parameter int NB_REQ = 2);
  logic [NB_REQ-1:0]       m_req_i;
  logic [NB_REQ-1:0][31:0] m_addr_i;
  logic [NB_REQ-1:0]       m_we_i;
  logic [NB_REQ-1:0][3:0]  m_be_i;
  logic [NB_REQ-1:0][31:0] m_wdata_i;
  logic [NB_REQ-1:0][5:0]  m_atop_i;
  logic [NB_REQ-1:0]       m_gnt_o;
  logic [NB_REQ-1:0]       m_rvalid_o;
  logic [NB_REQ-1:0]       m_err_o;
  logic [31:0]             m_rdata_o;
  logic                    data_req_o;
  logic                    data_gnt_i;
  logic                    data_rvalid_i;
  logic                    data_err_i;
  logic [31:0]             data_addr_o;
  logic                    data_we_o;
  logic [3:0]              data_be_o;
  logic [31:0]             data_wdata_o;
  logic [5:0]              data_atop_o;
  logic [31:0]             data_rdata_i;
  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, m_atop_i,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i,
    output m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o, data_atop_o
  );
  modport master (
    output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, m_atop_i,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o, data_atop_o
  );
endinterface

// File: rtl/riscv_arb_id_fifo.sv
// riscv_arb_id_fifo: in-order FIFO of granted requester IDs awaiting their response
module riscv_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign data_out = mem_q[rd_q];
  always_comb begin
    do_push = push & ~full;
    do_pop = pop & ~empty;
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = data_in;
    wr_d = do_push ? ((wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d = do_pop ? ((rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/riscv_data_port_arbiter.sv
// riscv_data_port_arbiter: round-robin sharing of the core data-memory port with in-order response routing
module riscv_data_port_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int NB_REQ = ARB_NB_REQ,
  parameter int MAX_OUTST = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  riscv_data_port_arbiter_if.slave  bus,
  output logic                      unexp_resp_o,
  output logic                      busy_o
);
  localparam int IW = NB_REQ > 1 ? $clog2(NB_REQ) : 1;
  localparam int CW = $clog2(MAX_OUTST+1);
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, sel_q, sel_d, pick, sel, head;
  logic lock_q, lock_d, full, empty, req, hs, pop;
  logic [CW-1:0] count;
  arb_req_t pay;
  always_comb begin
    pick = rr_ptr_q;
    for (int i = NB_REQ-1; i >= 0; i--)
      if (bus.m_req_i[rr_idx(int'(rr_ptr_q), i, NB_REQ)]) pick = IW'(rr_idx(int'(rr_ptr_q), i, NB_REQ));
  end
  // full blocks new requests even when a pop lands in the same cycle, so gnt never depends on rvalid
  always_comb begin
    sel = lock_q ? sel_q : pick;
    req = rst_ni & (|bus.m_req_i) & ~full;
    hs = req & bus.data_gnt_i;
    pop = bus.data_rvalid_i & ~empty;
    sel_d = sel;
    lock_d = hs ? 1'b0 : req;
    rr_ptr_d = hs ? IW'(rr_idx(int'(sel), 1, NB_REQ)) : rr_ptr_q;
    pay = '{addr: bus.m_addr_i[sel], we: bus.m_we_i[sel], be: bus.m_be_i[sel],
            wdata: bus.m_wdata_i[sel], atop: bus.m_atop_i[sel]};
  end
  riscv_arb_id_fifo #(.DEPTH(MAX_OUTST), .WIDTH(IW)) u_id_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (hs),
    .pop      (pop),
    .data_in  (sel),
    .data_out (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );
  assign bus.data_req_o = req;
  assign {bus.data_addr_o, bus.data_we_o, bus.data_be_o, bus.data_wdata_o, bus.data_atop_o} = req ? pay : '0;
  assign bus.m_gnt_o = NB_REQ'(hs) << sel;
  assign bus.m_rvalid_o = NB_REQ'(pop) << head;
  assign bus.m_err_o = NB_REQ'(pop & bus.data_err_i) << head;
  assign bus.m_rdata_o = rst_ni ? bus.data_rdata_i : '0;
  assign unexp_resp_o = rst_ni & bus.data_rvalid_i & empty;
  assign busy_o = (count != '0) | req;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      sel_q <= '0;
      lock_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      sel_q <= sel_d;
      lock_q <= lock_d;
    end
  end
endmodule

// File: tb/tb_riscv_data_port_arbiter.sv
// tb_riscv_data_port_arbiter: directed checks of arbitration, lock, outstanding limit, and response routing
module tb_riscv_data_port_arbiter;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic unexp, busy;
  int nvec = 0;
  int nerr = 0;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_0100;
  always #5 clk = ~clk;
  riscv_data_port_arbiter_if #(.NB_REQ(2)) b();
  riscv_data_port_arbiter #(.NB_REQ(2), .MAX_OUTST(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .bus          (b),
    .unexp_resp_o (unexp),
    .busy_o       (busy)
  );
  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd, input logic er);
    b.m_req_i = req;
    b.data_gnt_i = gnt;
    b.data_rvalid_i = rv;
    b.data_rdata_i = rd;
    b.data_err_i = er;
  endtask
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    drive(2'b11, 1'b1, 1'b1, 32'h5555_5555, 1'b1);
    #1;
    nvec++; if (b.data_req_o !== 1'b0) begin nerr++; $display("FAIL rst_req: got %b want 0", b.data_req_o); end
    nvec++; if (b.m_gnt_o !== 2'b00) begin nerr++; $display("FAIL rst_gnt: got %b want 00", b.m_gnt_o); end
    nvec++; if (b.m_rvalid_o !== 2'b00) begin nerr++; $display("FAIL rst_rvalid: got %b want 00", b.m_rvalid_o); end
    nvec++; if (b.data_addr_o !== 32'h0) begin nerr++; $display("FAIL rst_addr: got %h want 0", b.data_addr_o); end
    nvec++; if (b.m_rdata_o !== 32'h0) begin nerr++; $display("FAIL rst_rdata: got %h want 0", b.m_rdata_o); end
    nvec++; if ({unexp, busy} !== 2'b00) begin nerr++; $display("FAIL rst_flags: got %b want 00", {unexp, busy}); end
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    next_cycle();
    rst_ni = 1'b1;
  endtask
  task automatic test_single;
    next_cycle();
    drive(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    nvec++; if (b.m_gnt_o !== 2'b10) begin nerr++; $display("FAIL t1_gnt: got %b want 10", b.m_gnt_o); end
    nvec++; if (b.data_addr_o !== A1) begin nerr++; $display("FAIL t1_addr: got %h want %h", b.data_addr_o, A1); end
    nvec++; if (b.data_wdata_o !== 32'hBBBB_0001) begin nerr++; $display("FAIL t1_wdata: got %h want bbbb0001", b.data_wdata_o); end
    nvec++; if ({b.data_we_o, b.data_be_o, b.data_atop_o} !== {1'b1, 4'hC, 6'h21}) begin nerr++; $display("FAIL t1_ctl: got %b want 1_1100_100001", {b.data_we_o, b.data_be_o, b.data_atop_o}); end
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    #1;
    nvec++; if (b.m_rvalid_o !== 2'b10) begin nerr++; $display("FAIL t1_rvalid: got %b want 10", b.m_rvalid_o); end
    nvec++; if (b.m_rdata_o !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL t1_rdata: got %h want deadbeef", b.m_rdata_o); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL t1_busy: got %b want 1", busy); end
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    nvec++; if ({b.m_rvalid_o, busy} !== 3'b000) begin nerr++; $display("FAIL t1_idle: got %b want 000", {b.m_rvalid_o, busy}); end
  endtask
  task automatic test_alternate;
    logic [1:0] g, pg;
    pg = 2'b00;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive(2'b11, 1'b1, k > 0, 32'hA000 + k, k == 2);
      #1;
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      nvec++; if (b.m_gnt_o !== g) begin nerr++; $display("FAIL t2_gnt%0d: got %b want %b", k, b.m_gnt_o, g); end
      nvec++; if (b.data_addr_o !== (g[0] ? A0 : A1)) begin nerr++; $display("FAIL t2_addr%0d: got %h want %h", k, b.data_addr_o, g[0] ? A0 : A1); end
      nvec++; if (b.m_rvalid_o !== pg) begin nerr++; $display("FAIL t2_rvalid%0d: got %b want %b", k, b.m_rvalid_o, pg); end
      nvec++; if (b.m_err_o !== ((k == 2) ? pg : 2'b00)) begin nerr++; $display("FAIL t2_err%0d: got %b want %b", k, b.m_err_o, (k == 2) ? pg : 2'b00); end
      pg = g;
    end
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'hA004, 1'b0);
    #1;
    nvec++; if (b.m_rvalid_o !== 2'b10) begin nerr++; $display("FAIL t2_last_rvalid: got %b want 10", b.m_rvalid_o); end
    nvec++; if (b.m_rdata_o !== 32'hA004) begin nerr++; $display("FAIL t2_last_rdata: got %h want 0000a004", b.m_rdata_o); end
  endtask
  task automatic test_outstanding;
    logic [9:0] g_tab, rv_tab, rq_tab;
    g_tab = 10'b0001000011;
    rv_tab = 10'b1100100000;
    rq_tab = 10'b0011111111;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      drive({1'b0, rq_tab[k]}, 1'b1, rv_tab[k], 32'h0, 1'b0);
      #1;
      nvec++; if (b.m_gnt_o !== {1'b0, g_tab[k]}) begin nerr++; $display("FAIL t3_gnt%0d: got %b want %b", k, b.m_gnt_o, {1'b0, g_tab[k]}); end
      nvec++; if (b.data_req_o !== g_tab[k]) begin nerr++; $display("FAIL t3_req%0d: got %b want %b", k, b.data_req_o, g_tab[k]); end
      nvec++; if (b.m_rvalid_o !== {1'b0, rv_tab[k]}) begin nerr++; $display("FAIL t3_rvalid%0d: got %b want %b", k, b.m_rvalid_o, {1'b0, rv_tab[k]}); end
      nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL t3_busy%0d: got %b want 1", k, busy); end
    end
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL t3_drained: got %b want 0", busy); end
  endtask
  task automatic test_lock;
    logic [9:0] rq_tab, eg_tab;
    logic [4:0] gn_tab;
    rq_tab = {2'b10, 2'b11, 2'b11, 2'b01, 2'b01};
    gn_tab = 5'b11000;
    eg_tab = {2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      drive(rq_tab[2*k +: 2], gn_tab[k], 1'b0, 32'h0, 1'b0);
      #1;
      nvec++; if (b.m_gnt_o !== eg_tab[2*k +: 2]) begin nerr++; $display("FAIL t4_gnt%0d: got %b want %b", k, b.m_gnt_o, eg_tab[2*k +: 2]); end
      nvec++; if (b.data_addr_o !== ((k == 4) ? A1 : A0)) begin nerr++; $display("FAIL t4_addr%0d: got %h want %h", k, b.data_addr_o, (k == 4) ? A1 : A0); end
      nvec++; if (b.data_req_o !== 1'b1) begin nerr++; $display("FAIL t4_req%0d: got %b want 1", k, b.data_req_o); end
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
      #1;
      nvec++; if (b.m_rvalid_o !== ((k == 0) ? 2'b01 : 2'b10)) begin nerr++; $display("FAIL t4_rvalid%0d: got %b want %b", k, b.m_rvalid_o, (k == 0) ? 2'b01 : 2'b10); end
    end
  endtask
  task automatic test_unexpected;
    next_cycle();
    drive(2'b00, 1'b0, 1'b1, 32'h1234, 1'b1);
    #1;
    nvec++; if (unexp !== 1'b1) begin nerr++; $display("FAIL t5_unexp: got %b want 1", unexp); end
    nvec++; if ({b.m_rvalid_o, b.m_err_o} !== 4'b0000) begin nerr++; $display("FAIL t5_rvalid: got %b want 0000", {b.m_rvalid_o, b.m_err_o}); end
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    nvec++; if ({unexp, busy} !== 2'b00) begin nerr++; $display("FAIL t5_after: got %b want 00", {unexp, busy}); end
  endtask
  task automatic test_reset_mid;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      nvec++; if (b.m_gnt_o !== 2'b01) begin nerr++; $display("FAIL t6_gnt%0d: got %b want 01", k, b.m_gnt_o); end
    end
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL t6_pre_busy: got %b want 1", busy); end
    rst_ni = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL t6_rst_busy: got %b want 0", busy); end
    next_cycle();
    rst_ni = 1'b1;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      drive(2'b00, 1'b0, 1'b1, 32'hCAFE_0000 + k, 1'b0);
      #1;
      nvec++; if (unexp !== 1'b1) begin nerr++; $display("FAIL t6_unexp%0d: got %b want 1", k, unexp); end
      nvec++; if (b.m_rvalid_o !== 2'b00) begin nerr++; $display("FAIL t6_rvalid%0d: got %b want 00", k, b.m_rvalid_o); end
    end
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    nvec++; if ({unexp, busy} !== 2'b00) begin nerr++; $display("FAIL t6_end: got %b want 00", {unexp, busy}); end
  endtask
  initial begin
    b.m_addr_i[0] = A0;
    b.m_addr_i[1] = A1;
    b.m_wdata_i[0] = 32'hAAAA_0000;
    b.m_wdata_i[1] = 32'hBBBB_0001;
    b.m_we_i = 2'b10;
    b.m_be_i[0] = 4'h3;
    b.m_be_i[1] = 4'hC;
    b.m_atop_i[0] = 6'h00;
    b.m_atop_i[1] = 6'h21;
    test_reset();
    test_single();
    test_alternate();
    test_outstanding();
    test_lock();
    test_unexpected();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
